// File: rtl/memory_access.sv
// Memory-access pipeline stage: single-master req/ack bus loads/stores with lane/extend logic.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module memory_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] alu_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  input  logic        reg_write_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic        reg_write_o,
  output logic [4:0]  rd_o,
  output logic [31:0] result_o,
  output logic        align_err_o,
  output logic        bus_err_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [29:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [1:0]  req_lane;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        req_reg_write;
  logic [4:0]  req_rd;

  logic        is_mem;
  logic        misaligned;
  logic [3:0]  sel_nx;
  logic [31:0] dat_nx;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT - 1);
  logic [7:0] wdog;
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT);
  assign bus_err_o      = 1'b0;
`endif

  // Shift the addressed lane down to bit 0, then zero- or sign-extend.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign stall_o = (state == WAIT);

  always_comb begin
    is_mem     = mem_read_i | mem_write_i;
    misaligned = 1'b0;
    sel_nx     = 4'b1111;
    dat_nx     = rt_data_i;
    case (mem_size_i)
      2'b00: begin
        sel_nx = 4'b0001 << alu_data_i[1:0];
        dat_nx = {4{rt_data_i[7:0]}};
      end
      2'b01: begin
        sel_nx     = 4'b0011 << alu_data_i[1:0];
        dat_nx     = {2{rt_data_i[15:0]}};
        misaligned = alu_data_i[0];
      end
      default: misaligned = |alu_data_i[1:0];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      valid_o       <= 1'b0;
      reg_write_o   <= 1'b0;
      rd_o          <= '0;
      result_o      <= '0;
      align_err_o   <= 1'b0;
      bus_stb_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_adr_o     <= '0;
      bus_sel_o     <= '0;
      bus_dat_o     <= '0;
      req_lane      <= '0;
      req_size      <= '0;
      req_signed    <= 1'b0;
      req_reg_write <= 1'b0;
      req_rd        <= '0;
`ifdef MEM_TIMEOUT_EN
      bus_err_o     <= 1'b0;
      wdog          <= '0;
`endif
    end else begin
      valid_o     <= 1'b0;
      align_err_o <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_o   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (valid_i) begin
            rd_o <= rd_i;
            if (!is_mem) begin
              valid_o     <= 1'b1;
              result_o    <= alu_data_i;
              reg_write_o <= reg_write_i;
            end else if (misaligned) begin
              valid_o     <= 1'b1;
              align_err_o <= 1'b1;
              result_o    <= '0;
              reg_write_o <= 1'b0;
            end else begin
              bus_stb_o     <= 1'b1;
              bus_we_o      <= mem_write_i;
              bus_adr_o     <= alu_data_i[31:2];
              bus_sel_o     <= sel_nx;
              bus_dat_o     <= dat_nx;
              req_lane      <= alu_data_i[1:0];
              req_size      <= mem_size_i;
              req_signed    <= mem_signed_i;
              req_reg_write <= reg_write_i;
              req_rd        <= rd_i;
`ifdef MEM_TIMEOUT_EN
              wdog          <= '0;
`endif
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          // Ack takes priority over the watchdog limit on the same cycle.
          if (bus_ack_i) begin
            bus_stb_o <= 1'b0;
            valid_o   <= 1'b1;
            rd_o      <= req_rd;
            state     <= IDLE;
            if (bus_we_o) begin
              result_o    <= {bus_adr_o, req_lane};
              reg_write_o <= 1'b0;
            end else begin
              result_o    <= extend_load(bus_dat_i, req_lane, req_size, req_signed);
              reg_write_o <= req_reg_write;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (wdog == TIMEOUT_LIM) begin
            bus_stb_o   <= 1'b0;
            valid_o     <= 1'b1;
            bus_err_o   <= 1'b1;
            result_o    <= '0;
            reg_write_o <= 1'b0;
            rd_o        <= req_rd;
            state       <= IDLE;
          end else begin
            wdog <= wdog + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Table-driven bench for memory_access plus directed reset, back-to-back and watchdog sequences.
module tb_memory_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] alu_data_i;
  logic [31:0] rt_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [1:0]  mem_size_i;
  logic        mem_signed_i;
  logic        reg_write_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        valid_o;
  logic        reg_write_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;
  logic        align_err_o;
  logic        bus_err_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [29:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;

  memory_access #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_data_i(alu_data_i),
    .rt_data_i(rt_data_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_size_i(mem_size_i), .mem_signed_i(mem_signed_i), .reg_write_i(reg_write_i),
    .rd_i(rd_i), .stall_o(stall_o), .valid_o(valid_o), .reg_write_o(reg_write_o),
    .rd_o(rd_o), .result_o(result_o), .align_err_o(align_err_o), .bus_err_o(bus_err_o),
    .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] bdat;
    logic        mrd;
    logic        mwr;
    logic [1:0]  size;
    logic        sgn;
    logic        rw;
    logic [4:0]  rd;
    int          ack_cyc;
    logic [31:0] exp_res;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic        exp_rw;
    logic        exp_align;
    int          exp_stall;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [31:0] bdat, input logic mrd, input logic mwr,
                         input logic [1:0] size, input logic sgn, input logic rw,
                         input logic [4:0] rd, input int ack_cyc, input logic [31:0] exp_res,
                         input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                         input logic exp_rw, input logic exp_align, input int exp_stall);
    vec_t v;
    v.name = name; v.alu = alu; v.rt = rt; v.bdat = bdat; v.mrd = mrd; v.mwr = mwr;
    v.size = size; v.sgn = sgn; v.rw = rw; v.rd = rd; v.ack_cyc = ack_cyc;
    v.exp_res = exp_res; v.exp_sel = exp_sel; v.exp_dat = exp_dat; v.exp_rw = exp_rw;
    v.exp_align = exp_align; v.exp_stall = exp_stall;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    bit  done;
    @(negedge clk_i);
    valid_i = 1'b1; alu_data_i = v.alu; rt_data_i = v.rt; mem_read_i = v.mrd;
    mem_write_i = v.mwr; mem_size_i = v.size; mem_signed_i = v.sgn;
    reg_write_i = v.rw; rd_i = v.rd; bus_dat_i = v.bdat; bus_ack_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        n++;
        if (n == 1) begin
          chk({v.name, " stb"}, bus_stb_o, 1'b1);
          chk({v.name, " sel"}, bus_sel_o, v.exp_sel);
          chk({v.name, " adr"}, bus_adr_o, v.alu[31:2]);
          chk({v.name, " we"}, bus_we_o, v.mwr);
          if (v.mwr) chk({v.name, " wdat"}, bus_dat_o, v.exp_dat);
        end
        bus_ack_i = (n == v.ack_cyc);
        @(posedge clk_i);
        @(negedge clk_i);
        bus_ack_i = 1'b0;
      end
    end
    chk({v.name, " stall_cycles"}, n, v.exp_stall);
    chk({v.name, " valid"}, valid_o, 1'b1);
    chk({v.name, " result"}, result_o, v.exp_res);
    chk({v.name, " reg_write"}, reg_write_o, v.exp_rw);
    chk({v.name, " rd"}, rd_o, v.rd);
    chk({v.name, " align_err"}, align_err_o, v.exp_align);
    chk({v.name, " bus_err"}, bus_err_o, 1'b0);
    chk({v.name, " stb_low"}, bus_stb_o, 1'b0);
    @(negedge clk_i);
    chk({v.name, " valid_pulse"}, valid_o, 1'b0);
    chk({v.name, " align_pulse"}, align_err_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; alu_data_i = '0; rt_data_i = '0; mem_read_i = 1'b0;
    mem_write_i = 1'b0; mem_size_i = 2'b00; mem_signed_i = 1'b0; reg_write_i = 1'b0;
    rd_i = '0; bus_dat_i = '0; bus_ack_i = 1'b0;

    //          name      alu           rt            bdat          rd wr sz sg rw rd ack exp_res       sel    wdat          rw al stall
    add_vec("alu_pass", 32'h1234_5678, 32'h0,        32'h0,        0, 0, 2, 0, 1, 5,  0, 32'h1234_5678, 4'h0, 32'h0,        1, 0, 0);
    add_vec("lb_s",     32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 0, 0, 1, 1, 3,  4, 32'hFFFF_FF80, 4'h8, 32'h0,        1, 0, 4);
    add_vec("lbu",      32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 0, 0, 0, 1, 3,  4, 32'h0000_0080, 4'h8, 32'h0,        1, 0, 4);
    add_vec("sh",       32'h0000_0202, 32'hAAAA_BEEF, 32'h0,        0, 1, 1, 0, 1, 4,  1, 32'h0000_0202, 4'hC, 32'hBEEF_BEEF, 0, 0, 1);
    add_vec("lw_mis",   32'h0000_0301, 32'h0,        32'h0,        1, 0, 2, 0, 1, 6,  0, 32'h0,        4'h0, 32'h0,        0, 1, 0);
    add_vec("lh_s",     32'h0000_0102, 32'h0,        32'h8001_1234, 1, 0, 1, 1, 1, 7,  2, 32'hFFFF_8001, 4'hC, 32'h0,        1, 0, 2);
    add_vec("lhu",      32'h0000_0100, 32'h0,        32'h8001_F234, 1, 0, 1, 0, 1, 8,  3, 32'h0000_F234, 4'h3, 32'h0,        1, 0, 3);
    add_vec("lw",       32'h0000_0400, 32'h0,        32'hDEAD_BEEF, 1, 0, 2, 0, 1, 9,  1, 32'hDEAD_BEEF, 4'hF, 32'h0,        1, 0, 1);
    add_vec("sb",       32'h0000_0501, 32'h1234_56A5, 32'h0,        0, 1, 0, 0, 1, 10, 2, 32'h0000_0501, 4'h2, 32'hA5A5_A5A5, 0, 0, 2);
    add_vec("sh_mis",   32'h0000_0203, 32'h0,        32'h0,        0, 1, 1, 0, 1, 11, 0, 32'h0,        4'h0, 32'h0,        0, 1, 0);
    add_vec("lw_sz3",   32'h0000_0604, 32'h0,        32'h0102_0304, 1, 0, 3, 0, 1, 12, 1, 32'h0102_0304, 4'hF, 32'h0,        1, 0, 1);
    add_vec("lb_pos",   32'h0000_0100, 32'h0,        32'h0000_007F, 1, 0, 0, 1, 1, 13, 1, 32'h0000_007F, 4'h1, 32'h0,        1, 0, 1);
    add_vec("alu_rw0",  32'hFFFF_0000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 31, 0, 32'hFFFF_0000, 4'h0, 32'h0,        0, 0, 0);

    #12;
    chk("rst stall", stall_o, 1'b0);
    chk("rst valid", valid_o, 1'b0);
    chk("rst stb", bus_stb_o, 1'b0);
    chk("rst we", bus_we_o, 1'b0);
    chk("rst adr", bus_adr_o, 30'h0);
    chk("rst sel", bus_sel_o, 4'h0);
    chk("rst dat", bus_dat_o, 32'h0);
    chk("rst result", result_o, 32'h0);
    chk("rst reg_write", reg_write_o, 1'b0);
    chk("rst rd", rd_o, 5'h0);
    chk("rst align_err", align_err_o, 1'b0);
    chk("rst bus_err", bus_err_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vq[i]) run_vec(vq[i]);

    // Reset while waiting on the bus, then a late ack must be ignored.
    @(negedge clk_i);
    valid_i = 1'b1; alu_data_i = 32'h0000_0700; mem_read_i = 1'b1; mem_size_i = 2'b10;
    reg_write_i = 1'b1; rd_i = 5'd2; bus_dat_i = 32'h5555_AAAA;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0; mem_read_i = 1'b0;
    chk("rstw stb_before", bus_stb_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    chk("rstw stb_async", bus_stb_o, 1'b0);
    chk("rstw stall_async", stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus_ack_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    chk("rstw late_ack_valid", valid_o, 1'b0);
    chk("rstw late_ack_stall", stall_o, 1'b0);
    @(negedge clk_i);
    chk("rstw late_ack_valid2", valid_o, 1'b0);
    chk("rstw result", result_o, 32'h0);

    // Held load with zero-wait ack, next instruction accepted the cycle after ack.
    @(negedge clk_i);
    valid_i = 1'b1; alu_data_i = 32'h0000_0800; mem_read_i = 1'b1; mem_size_i = 2'b10;
    mem_signed_i = 1'b0; reg_write_i = 1'b1; rd_i = 5'd7; bus_dat_i = 32'h1122_3344;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("b2b stall", stall_o, 1'b1);
    chk("b2b stb", bus_stb_o, 1'b1);
    bus_ack_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    chk("b2b stall_after_ack", stall_o, 1'b0);
    chk("b2b load_valid", valid_o, 1'b1);
    chk("b2b load_result", result_o, 32'h1122_3344);
    mem_read_i = 1'b0; alu_data_i = 32'hCAFE_0001; rd_i = 5'd9;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("b2b alu_valid", valid_o, 1'b1);
    chk("b2b alu_result", result_o, 32'hCAFE_0001);
    chk("b2b alu_rd", rd_o, 5'd9);
    chk("b2b alu_stall", stall_o, 1'b0);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      @(negedge clk_i);
      valid_i = 1'b1; alu_data_i = 32'h0000_0900; mem_read_i = 1'b1; mem_size_i = 2'b10;
      reg_write_i = 1'b1; rd_i = 5'd3; bus_ack_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0; mem_read_i = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && bus_stb_o; c++) begin
        n++;
        @(posedge clk_i);
        @(negedge clk_i);
      end
      chk("tmo stb_cycles", n, 4);
      chk("tmo valid", valid_o, 1'b1);
      chk("tmo bus_err", bus_err_o, 1'b1);
      chk("tmo reg_write", reg_write_o, 1'b0);
      chk("tmo result", result_o, 32'h0);
      chk("tmo stall", stall_o, 1'b0);
      @(negedge clk_i);
      chk("tmo bus_err_pulse", bus_err_o, 1'b0);
      chk("tmo valid_pulse", valid_o, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
